// File: rtl/piso_shift_reg_param.sv
// piso_shift_reg_param: parallel-in / serial-out shift register with a
// valid/ready load handshake. A WIDTH-bit word is taken on d and sent one
// bit per enabled cycle on q. Back-to-back words stream without a gap,
// because a new word can be taken in the same cycle the last bit leaves.
module piso_shift_reg_param #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             q,
    output logic             q_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;

    logic             last_bit_s;
    logic             accept_s;
    logic [WIDTH-1:0] shreg_shifted_s;

    // The last bit of a word sits on q when the counter has reached zero.
    assign last_bit_s = (state_q == S_SHIFT) && (cnt_q == '0);

    // Ready in IDLE, or in SHIFT exactly when the final bit is being taken;
    // clr always blocks acceptance so a reset cycle never loads a word.
    assign load_ready = !clr && ((state_q == S_IDLE) || (last_bit_s && shift_en));
    assign accept_s   = load_valid && load_ready;

    // Zero-filled shift toward the output end selected by MSB_FIRST.
    assign shreg_shifted_s = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    // Outputs decode registered state only; no input reaches q/q_valid/busy.
    assign q_valid = (state_q == S_SHIFT);
    assign busy    = (state_q == S_SHIFT);
    assign q       = (state_q == S_SHIFT)
                     ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0])
                     : IDLE_LEVEL;
    assign done    = done_q;

    // Next-state logic: load, shift, stall, reload-on-last-bit and drain to IDLE.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    shreg_d = d;
                    cnt_d   = CNT_LAST;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (!shift_en) begin
                    state_d = S_SHIFT;
                end else if (cnt_q != '0) begin
                    shreg_d = shreg_shifted_s;
                    cnt_d   = cnt_q - CNT_ONE;
                end else begin
                    done_d = 1'b1;
                    if (accept_s) begin
                        shreg_d = d;
                        cnt_d   = CNT_LAST;
                        state_d = S_SHIFT;
                    end else begin
                        shreg_d = shreg_shifted_s;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; clr takes priority over every other input.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_reg_param.sv
// Testbench for piso_shift_reg_param. Three instances cover MSB-first and
// LSB-first 4-bit words plus an 8-bit MSB-first variant with IDLE_LEVEL=1.
// A scoreboard queue holds the expected serial bits of accepted words.
module tb_piso_shift_reg_param;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] d;
    logic       load_valid;
    logic       shift_en;
    int         sel;

    logic lr0, q0, qv0, bz0, dn0;
    logic lr1, q1, qv1, bz1, dn1;
    logic lr2, q2, qv2, bz2, dn2;
    logic m_lr, m_q, m_qv, m_busy, m_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_done   = 0;

    bit qb[$];
    bit ql[$];
    bit done_exp;

    always #5 clk = ~clk;

    piso_shift_reg_param #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
        .clk(clk), .clr(clr), .d(d[3:0]), .load_valid(load_valid && (sel == 0)),
        .load_ready(lr0), .shift_en(shift_en), .q(q0), .q_valid(qv0), .busy(bz0), .done(dn0));
    piso_shift_reg_param #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
        .clk(clk), .clr(clr), .d(d[3:0]), .load_valid(load_valid && (sel == 1)),
        .load_ready(lr1), .shift_en(shift_en), .q(q1), .q_valid(qv1), .busy(bz1), .done(dn1));
    piso_shift_reg_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u2 (
        .clk(clk), .clr(clr), .d(d), .load_valid(load_valid && (sel == 2)),
        .load_ready(lr2), .shift_en(shift_en), .q(q2), .q_valid(qv2), .busy(bz2), .done(dn2));

    // Route the outputs of the instance under test to the monitor signals.
    always_comb begin
        case (sel)
            0:       {m_lr, m_q, m_qv, m_busy, m_done} = {lr0, q0, qv0, bz0, dn0};
            1:       {m_lr, m_q, m_qv, m_busy, m_done} = {lr1, q1, qv1, bz1, dn1};
            default: {m_lr, m_q, m_qv, m_busy, m_done} = {lr2, q2, qv2, bz2, dn2};
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, act, exp, $time, sel);
        end
    endtask

    // One clock cycle: compare outputs against the model, update the
    // scoreboard with this cycle's consumption and handshake, then clock.
    task automatic cyc();
        int  w;
        bit  msb;
        bit  idl;
        bit  exp_qv;
        bit  exp_lr;
        bit  nd;
        int  idx;
        #1;
        w      = (sel == 2) ? 8 : 4;
        msb    = (sel != 1);
        idl    = (sel == 2);
        exp_qv = (qb.size() != 0);
        exp_lr = !clr && ((qb.size() == 0) || (shift_en && qb.size() == 1));
        check_val("q_valid", m_qv, exp_qv);
        check_val("busy", m_busy, exp_qv);
        check_val("load_ready", m_lr, exp_lr);
        check_val("done", m_done, done_exp);
        check_val("q", m_q, exp_qv ? qb[0] : idl);
        if (m_done) n_done++;
        nd = 1'b0;
        if (clr) begin
            qb.delete();
            ql.delete();
        end else begin
            if (exp_qv && shift_en) begin
                nd = ql[0];
                void'(qb.pop_front());
                void'(ql.pop_front());
            end
            if (load_valid && exp_lr) begin
                n_acc++;
                for (int i = 0; i < w; i++) begin
                    idx = msb ? (w - 1 - i) : i;
                    qb.push_back(d[idx]);
                    ql.push_back(i == w - 1);
                end
            end
        end
        @(posedge clk);
        done_exp = nd;
        @(negedge clk);
    endtask

    task automatic drive(input bit c, input bit lv, input logic [7:0] dv, input bit se);
        clr        = c;
        load_valid = lv;
        d          = dv;
        shift_en   = se;
        cyc();
    endtask

    initial begin
        sel        = 0;
        clr        = 1'b1;
        load_valid = 1'b0;
        d          = 8'h00;
        shift_en   = 1'b0;
        done_exp   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then MSB-first 4'b0100.
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h04, 1'b1);
        repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);

        // LSB-first 4'b1110.
        sel = 1;
        drive(1'b0, 1'b1, 8'h0E, 1'b1);
        repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);

        // Back-to-back 4'b1010 then 4'b0011 with load_valid held.
        sel = 0;
        drive(1'b0, 1'b1, 8'h0A, 1'b1);
        repeat (4) drive(1'b0, 1'b1, 8'h03, 1'b1);
        repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);

        // Stall for 3 cycles after the 2nd bit.
        drive(1'b0, 1'b1, 8'h0B, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset on the 3rd bit of 8'hA5 with a competing load, then 8'h3C.
        sel = 2;
        drive(1'b0, 1'b1, 8'hA5, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h3C, 1'b1);
        repeat (10) drive(1'b0, 1'b0, 8'h00, 1'b1);

        // load_valid held with d changing every cycle and random throttling.
        sel    = 1;
        n_acc  = 0;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (12) drive(1'b0, 1'b0, 8'h00, 1'b1);
        check_val("word_count", n_done, n_acc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
